// File: rtl/mul32_seq.sv
// mul32_seq: 32x32->64 shift-add multiplier, one partial product per cycle, with SF/ZF/PF flags.
// Optional signed mode under `MUL_SIGNED_EN` (magnitude multiply, negate when signs differ).
module mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        SF,
  output logic        ZF,
  output logic        PF
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] m_q, m_d, q_q, q_d, mag_a, mag_b;
  logic [32:0] acc_q, acc_d, sum;
  logic [5:0] cnt_q, cnt_d;
  logic neg_q, neg_d, neg_in, busy_q, busy_d, done_q, done_d, accept, unused_ok;
  logic [63:0] prod_q, prod_d, raw;
  logic sf_q, zf_q, pf_q;
  assign accept = start & ~busy_q;
  assign sum = {1'b0, acc_q[31:0]} + (q_q[0] ? {1'b0, m_q} : 33'd0);
  assign raw = {acc_q[31:0], q_q};
`ifdef MUL_SIGNED_EN
  assign mag_a = (signed_op & A[31]) ? -A : A;
  assign mag_b = (signed_op & B[31]) ? -B : B;
  assign neg_in = signed_op & (A[31] ^ B[31]);
  assign prod_d = neg_q ? -raw : raw;
`else
  assign mag_a = A;
  assign mag_b = B;
  assign neg_in = 1'b0;
  assign prod_d = raw;
`endif
  assign unused_ok = ^{acc_q[32], signed_op, neg_q};
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    q_d = q_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    done_d = state_q == DONE;
    busy_d = accept | (busy_q & ~done_q);
    if (state_q == IDLE && accept) begin
      m_d = mag_a;
      q_d = mag_b;
      acc_d = '0;
      cnt_d = '0;
      neg_d = neg_in;
      state_d = RUN;
    end else if (state_q == RUN) begin
      acc_d = {1'b0, sum[32:1]};
      q_d = {sum[0], q_q[31:1]};
      cnt_d = cnt_q + 6'd1;
      state_d = (cnt_q == 6'd31) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      q_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      prod_q <= '0;
      sf_q <= 1'b0;
      zf_q <= 1'b0;
      pf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      q_q <= q_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (state_q == DONE) begin
        prod_q <= prod_d;
        sf_q <= prod_d[63];
        zf_q <= prod_d == 64'd0;
        pf_q <= ^prod_d;
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign product = prod_q;
  assign SF = sf_q;
  assign ZF = zf_q;
  assign PF = pf_q;
endmodule
